// File: rtl/pipe_ctrl_track.sv
// pipe_ctrl_track: carries per-instruction WB/MEM control bits through ID->EXE->MEM->WB
// and returns per-stage feedback plus retired-instruction and bubble counters.
module pipe_ctrl_track #(
    parameter int CNT_W = 32,
    parameter logic [4:0] LINK_REG = 5'd31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic             id_en,
    input  logic             id_rst,
    input  logic             exe_en,
    input  logic             exe_rst,
    input  logic             mem_en,
    input  logic             mem_rst,
    input  logic             wb_en,
    input  logic             wb_rst,
    input  logic [31:0]      inst,
    input  logic             wb_wen,
    input  logic [1:0]       wb_addr_src,
    input  logic             wb_data_src,
    input  logic             mem_ren,
    input  logic             mem_wen,
    input  logic             is_load,
    input  logic             fwd_m,
    output logic             id_valid,
    output logic             exe_valid,
    output logic             mem_valid,
    output logic             wb_valid,
    output logic [4:0]       regw_addr_exe,
    output logic [4:0]       regw_addr_mem,
    output logic [4:0]       regw_addr_wb,
    output logic             wb_wen_exe,
    output logic             wb_wen_mem,
    output logic             wb_wen_wb,
    output logic             is_load_exe,
    output logic             mem_ren_mem,
    output logic             mem_wen_mem,
    output logic             fwd_m_mem,
    output logic             wb_data_src_wb,
    output logic [CNT_W-1:0] instret,
    output logic [CNT_W-1:0] bubble_cnt
);
    logic [4:0] id_addr;
    logic       id_wen;
    logic       exe_mem_ren;
    logic       exe_mem_wen;
    logic       exe_fwd_m;
    logic       exe_wb_data_src;
    logic       mem_wb_data_src;
    logic       unused_inst;

    assign unused_inst = ^{inst[31:21], inst[10:0]};

    // Reserved source 3 decodes to a harmless no-write to $0.
    assign id_addr = wb_addr_src == 2'd0 ? inst[15:11] :
                     wb_addr_src == 2'd1 ? inst[20:16] :
                     wb_addr_src == 2'd2 ? LINK_REG : 5'd0;
    assign id_wen  = wb_wen & id_valid & (wb_addr_src != 2'd3);

    always_ff @(posedge clk) begin
        if (rst || id_rst)
            id_valid <= 1'b0;
        else if (id_en)
            id_valid <= if_valid;
    end

    always_ff @(posedge clk) begin
        if (rst || exe_rst) begin
            exe_valid       <= 1'b0;
            regw_addr_exe   <= 5'd0;
            wb_wen_exe      <= 1'b0;
            is_load_exe     <= 1'b0;
            exe_mem_ren     <= 1'b0;
            exe_mem_wen     <= 1'b0;
            exe_fwd_m       <= 1'b0;
            exe_wb_data_src <= 1'b0;
        end else if (exe_en) begin
            exe_valid       <= id_valid;
            regw_addr_exe   <= id_addr;
            wb_wen_exe      <= id_wen;
            is_load_exe     <= is_load & id_valid;
            exe_mem_ren     <= mem_ren & id_valid;
            exe_mem_wen     <= mem_wen & id_valid;
            exe_fwd_m       <= fwd_m & id_valid;
            exe_wb_data_src <= wb_data_src;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || mem_rst) begin
            mem_valid       <= 1'b0;
            regw_addr_mem   <= 5'd0;
            wb_wen_mem      <= 1'b0;
            mem_ren_mem     <= 1'b0;
            mem_wen_mem     <= 1'b0;
            fwd_m_mem       <= 1'b0;
            mem_wb_data_src <= 1'b0;
        end else if (mem_en) begin
            mem_valid       <= exe_valid;
            regw_addr_mem   <= regw_addr_exe;
            wb_wen_mem      <= wb_wen_exe;
            mem_ren_mem     <= exe_mem_ren;
            mem_wen_mem     <= exe_mem_wen;
            fwd_m_mem       <= exe_fwd_m;
            mem_wb_data_src <= exe_wb_data_src;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || wb_rst) begin
            wb_valid       <= 1'b0;
            regw_addr_wb   <= 5'd0;
            wb_wen_wb      <= 1'b0;
            wb_data_src_wb <= 1'b0;
        end else if (wb_en) begin
            wb_valid       <= mem_valid;
            regw_addr_wb   <= regw_addr_mem;
            wb_wen_wb      <= wb_wen_mem;
            wb_data_src_wb <= mem_wb_data_src;
        end
    end

    // An instruction retires as it leaves WB, even if WB is squashed behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            instret    <= '0;
            bubble_cnt <= '0;
        end else begin
            instret    <= instret + CNT_W'(wb_valid & wb_en);
            bubble_cnt <= bubble_cnt + CNT_W'(exe_rst & id_valid);
        end
    end
endmodule

// File: tb/tb_pipe_ctrl_track.sv
// tb_pipe_ctrl_track: directed vectors plus hand sequences for stall, forward and wrap.
module tb_pipe_ctrl_track;
    logic clk = 1'b0;
    logic rst, if_valid, id_en, id_rst, exe_en, exe_rst, mem_en, mem_rst, wb_en, wb_rst;
    logic [31:0] inst;
    logic wb_wen, wb_data_src, mem_ren, mem_wen, is_load, fwd_m;
    logic [1:0] wb_addr_src;
    logic id_valid, exe_valid, mem_valid, wb_valid;
    logic [4:0] regw_addr_exe, regw_addr_mem, regw_addr_wb;
    logic wb_wen_exe, wb_wen_mem, wb_wen_wb, is_load_exe;
    logic mem_ren_mem, mem_wen_mem, fwd_m_mem, wb_data_src_wb;
    logic [3:0] instret, bubble_cnt;
    int tests = 0;
    int fails = 0;

    localparam logic [31:0] ADD3  = 32'h00221820;
    localparam logic [31:0] ADD0  = 32'h00220020;
    localparam logic [31:0] LW5   = 32'h8C250000;
    localparam logic [31:0] LW4   = 32'h8C240000;
    localparam logic [31:0] SW4   = 32'hAC240000;
    localparam logic [31:0] JAL   = 32'h0C000000;

    typedef struct {
        logic [31:0] inst;
        logic [1:0]  src;
        logic        wen;
        logic        ld;
        logic [4:0]  ea;
        logic        ew;
        logic        el;
    } vec_t;
    vec_t tbl[7];

    pipe_ctrl_track #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid),
        .id_en(id_en), .id_rst(id_rst), .exe_en(exe_en), .exe_rst(exe_rst),
        .mem_en(mem_en), .mem_rst(mem_rst), .wb_en(wb_en), .wb_rst(wb_rst),
        .inst(inst), .wb_wen(wb_wen), .wb_addr_src(wb_addr_src), .wb_data_src(wb_data_src),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .is_load(is_load), .fwd_m(fwd_m),
        .id_valid(id_valid), .exe_valid(exe_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
        .regw_addr_exe(regw_addr_exe), .regw_addr_mem(regw_addr_mem), .regw_addr_wb(regw_addr_wb),
        .wb_wen_exe(wb_wen_exe), .wb_wen_mem(wb_wen_mem), .wb_wen_wb(wb_wen_wb),
        .is_load_exe(is_load_exe), .mem_ren_mem(mem_ren_mem), .mem_wen_mem(mem_wen_mem),
        .fwd_m_mem(fwd_m_mem), .wb_data_src_wb(wb_data_src_wb),
        .instret(instret), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic defaults();
        rst = 0; if_valid = 0;
        id_en = 1; exe_en = 1; mem_en = 1; wb_en = 1;
        id_rst = 0; exe_rst = 0; mem_rst = 0; wb_rst = 0;
        inst = 0; wb_wen = 0; wb_addr_src = 0; wb_data_src = 0;
        mem_ren = 0; mem_wen = 0; is_load = 0; fwd_m = 0;
    endtask

    task automatic set_ctl(input logic [31:0] i, input logic [1:0] s, input logic w,
                           input logic ren, input logic ld, input logic wds,
                           input logic mw, input logic fm);
        inst = i; wb_addr_src = s; wb_wen = w; mem_ren = ren; is_load = ld;
        wb_data_src = wds; mem_wen = mw; fwd_m = fm;
    endtask

    task automatic do_reset();
        defaults();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic chk_all_zero(input string n);
        chk({n, " valids"}, {id_valid, exe_valid, mem_valid, wb_valid}, 0);
        chk({n, " addrs"}, {regw_addr_exe, regw_addr_mem, regw_addr_wb}, 0);
        chk({n, " flags"}, {wb_wen_exe, wb_wen_mem, wb_wen_wb, is_load_exe, mem_ren_mem,
                            mem_wen_mem, fwd_m_mem, wb_data_src_wb}, 0);
        chk({n, " instret"}, instret, 0);
        chk({n, " bubble_cnt"}, bubble_cnt, 0);
    endtask

    initial begin
        tbl[0] = '{ADD3, 2'd0, 1'b1, 1'b0, 5'd3,  1'b1, 1'b0};
        tbl[1] = '{LW5,  2'd1, 1'b1, 1'b1, 5'd5,  1'b1, 1'b1};
        tbl[2] = '{JAL,  2'd2, 1'b1, 1'b0, 5'd31, 1'b1, 1'b0};
        tbl[3] = '{ADD3, 2'd3, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0};
        tbl[4] = '{ADD3, 2'd0, 1'b0, 1'b0, 5'd3,  1'b0, 1'b0};
        tbl[5] = '{ADD3, 2'd1, 1'b1, 1'b0, 5'd2,  1'b1, 1'b0};
        tbl[6] = '{ADD0, 2'd0, 1'b1, 1'b0, 5'd0,  1'b1, 1'b0};

        // reset with random inputs
        defaults();
        {if_valid, id_en, id_rst, exe_en, exe_rst, mem_en, mem_rst, wb_en, wb_rst} = 9'($urandom);
        inst = $urandom;
        {wb_wen, wb_addr_src, wb_data_src, mem_ren, mem_wen, is_load, fwd_m} = 8'($urandom);
        rst = 1;
        step();
        step();
        chk_all_zero("reset");

        // decode vectors
        defaults();
        if_valid = 1;
        step();
        for (int i = 0; i < 7; i++) begin
            set_ctl(tbl[i].inst, tbl[i].src, tbl[i].wen, 1'b0, tbl[i].ld, 1'b0, 1'b0, 1'b0);
            step();
            chk($sformatf("vec%0d exe_valid", i), exe_valid, 1);
            chk($sformatf("vec%0d addr_exe", i), regw_addr_exe, tbl[i].ea);
            chk($sformatf("vec%0d wen_exe", i), wb_wen_exe, tbl[i].ew);
            chk($sformatf("vec%0d load_exe", i), is_load_exe, tbl[i].el);
            if (i >= 1) chk($sformatf("vec%0d addr_mem", i), regw_addr_mem, tbl[i-1].ea);
            if (i >= 1) chk($sformatf("vec%0d wen_mem", i), wb_wen_mem, tbl[i-1].ew);
            if (i >= 2) chk($sformatf("vec%0d addr_wb", i), regw_addr_wb, tbl[i-2].ea);
        end

        // add latency through the pipe
        do_reset();
        if_valid = 1;
        step();
        set_ctl(ADD3, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("add exe addr", regw_addr_exe, 3);
        chk("add exe wen", wb_wen_exe, 1);
        if_valid = 0; wb_wen = 0;
        step();
        chk("add mem addr", regw_addr_mem, 3);
        chk("add mem wen", wb_wen_mem, 1);
        step();
        chk("add wb addr", regw_addr_wb, 3);
        chk("add wb wen", wb_wen_wb, 1);
        chk("add wb valid", wb_valid, 1);
        chk("add instret before", instret, 0);
        step();
        chk("add instret after", instret, 1);

        // load stall; squash of empty ID is not a bubble
        do_reset();
        exe_rst = 1;
        step();
        chk("empty squash bubble", bubble_cnt, 0);
        exe_rst = 0; if_valid = 1;
        step();
        set_ctl(LW5, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        chk("lw exe load", is_load_exe, 1);
        set_ctl(ADD3, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        id_en = 0; exe_rst = 1;
        step();
        chk("stall exe_valid", exe_valid, 0);
        chk("stall wen_exe", wb_wen_exe, 0);
        chk("stall bubble_cnt", bubble_cnt, 1);
        chk("stall mem_ren_mem", mem_ren_mem, 1);
        chk("stall addr_mem", regw_addr_mem, 5);
        chk("stall id held", id_valid, 1);
        id_en = 1; exe_rst = 0;
        step();
        chk("resume exe addr", regw_addr_exe, 3);
        chk("resume exe valid", exe_valid, 1);
        chk("resume wb data src", wb_data_src_wb, 1);
        chk("resume bubble_cnt", bubble_cnt, 1);

        // lw then sw with forward from WB
        do_reset();
        if_valid = 1;
        step();
        set_ctl(LW4, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        set_ctl(SW4, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        chk("fwd lw in mem fwd", fwd_m_mem, 0);
        chk("fwd lw in mem ren", mem_ren_mem, 1);
        set_ctl(ADD3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("fwd sw fwd_m_mem", fwd_m_mem, 1);
        chk("fwd sw mem_wen_mem", mem_wen_mem, 1);
        chk("fwd lw wb data src", wb_data_src_wb, 1);
        chk("fwd lw wb addr", regw_addr_wb, 4);

        // instret wrap at 4 bits, then back-end freeze
        do_reset();
        if_valid = 1;
        set_ctl(ADD3, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step();
        chk("wrap first wb", instret, 0);
        for (int i = 0; i < 15; i++) step();
        chk("wrap max", instret, 15);
        step();
        chk("wrap zero", instret, 0);
        id_en = 0; exe_en = 0; mem_en = 0; wb_en = 0;
        inst = LW5; wb_addr_src = 2'd1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("freeze%0d addr_mem", i), regw_addr_mem, 3);
            chk($sformatf("freeze%0d wen_mem", i), wb_wen_mem, 1);
            chk($sformatf("freeze%0d instret", i), instret, 0);
        end

        // reset mid-operation beats enables
        id_en = 1; exe_en = 1; mem_en = 1; wb_en = 1;
        rst = 1;
        step();
        chk_all_zero("midrst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl_track.md
Name: pipe_ctrl_track

Overview:
- Pipeline control-tracking register bank for the MIPS 5-stage CPU; the responder end of the pipeline controller's stage-control interface.
- Takes per-stage enable/reset strobes and ID-stage decoded controls, and carries each instruction's write-back/memory control bits through the ID→EXE→MEM→WB registers.
- Returns the per-stage feedback (valid flags, write address, write enable, load/read flags) that the controller uses for forwarding and load-stall decisions.
- Keeps retired-instruction and inserted-bubble counters.

Parameters:
- CNT_W, 32, width of the instret and bubble_cnt counters.
- LINK_REG, 31, register index written when wb_addr_src = LINK.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- if_valid  in  1  IF stage holds a valid instruction
- id_en, id_rst, exe_en, exe_rst, mem_en, mem_rst, wb_en, wb_rst  in  1 each  stage enable/reset strobes from the controller
- inst  in  32  instruction currently in ID
- wb_wen  in  1  ID-decoded register write enable
- wb_addr_src  in  2  0=RD inst[15:11], 1=RT inst[20:16], 2=LINK, 3=reserved
- wb_data_src  in  1  0=ALU, 1=MEM
- mem_ren, mem_wen, is_load, fwd_m  in  1 each  ID-decoded controls
- id_valid, exe_valid, mem_valid, wb_valid  out  1 each  stage valid flags
- regw_addr_exe, regw_addr_mem, regw_addr_wb  out  5 each  destination register per stage
- wb_wen_exe, wb_wen_mem, wb_wen_wb  out  1 each  qualified write enables
- is_load_exe  out  1  EXE holds a load
- mem_ren_mem, mem_wen_mem  out  1 each  memory strobes for MEM
- fwd_m_mem  out  1  MEM store takes its data from the WB load result
- wb_data_src_wb  out  1  write-back data select
- instret  out  CNT_W  retired-instruction count
- bubble_cnt  out  CNT_W  count of controller-inserted EXE bubbles

Behaviour:
- ID write-address mux (combinational): src 0 gives inst[15:11], 1 gives inst[20:16], 2 gives LINK_REG. Src 3 forces address 0 and write enable 0.
- ID qualification: the ID-stage wen/ren/mem_wen/is_load/fwd_m are ANDed with id_valid before capture into EXE.
- Each stage register, evaluated every posedge, in priority order:
  - rst or <stage>_rst: clear all fields to 0 (valid=0, wen=0, addr=0, all flags=0).
  - else <stage>_en: capture the previous stage's fields.
  - else: hold.
- id_valid captures if_valid under the same rule. Source order: IF→ID→EXE→MEM→WB.
- Fields carried EXE→MEM: addr, wen, mem_ren, mem_wen, wb_data_src, fwd_m, valid. is_load_exe is the EXE copy of is_load.
- Every output is a direct register output; none are combinational from the inputs.
- Latency: a control field present in ID at edge N appears in EXE after N, in MEM after N+1, and in WB after N+2, provided all enables are high.
- Load stall (id_en=0, exe_rst=1, if_en=0): ID holds, EXE takes a bubble, and MEM and WB advance normally.
- bubble_cnt increments by 1 on every edge where exe_rst=1, rst=0 and id_valid=1; a squash of an empty ID is not counted.
- instret increments by 1 on every edge where wb_valid=1, wb_en=1 and rst=0. It counts the instruction leaving WB.
- Both counters wrap modulo 2^CNT_W with no saturation.
- Simultaneous <stage>_rst and <stage>_en: reset wins.
- rst mid-operation: all stages and both counters read 0 after the edge, regardless of enables.
- Writes to register 0 keep wen=1 as decoded; filtering of address 0 is done by the consumer.
- Reset value of every output: 0.

Test Plan:
- rst=1 for 2 cycles with all inputs at random values → all valid flags, addresses, enables, instret and bubble_cnt read 0.
- add $3,$1,$2 (src=0, wen=1) fed with all enables high → regw_addr_exe=3 and wb_wen_exe=1 at cycle+1; same values on the MEM outputs at +2 and WB outputs at +3; instret=1 one cycle later.
- lw $5,0($1) then dependent add; assert id_en=0, exe_rst=1 for one cycle → exe_valid=0, wb_wen_exe=0 and bubble_cnt=1 that cycle; lw reaches MEM with mem_ren_mem=1 and regw_addr_mem=5; add enters EXE the next cycle.
- lw $4 followed by sw $4 with fwd_m=1 → fwd_m_mem=1 and mem_wen_mem=1 exactly when the lw has wb_data_src_wb=1 in WB.
- jal (src=2, wen=1) → regw_addr_exe=31. Case src=3, wen=1 → regw_addr_exe=0 and wb_wen_exe=0.
- Force instret to 2^CNT_W−1 (CNT_W=4 build, 15 retirements), then retire one more → instret=0. Assert mem_en=0 for 3 cycles → MEM outputs stay stable and instret does not advance from MEM-held instructions.
